// File: rtl/uart_rx_if.sv
// Parallel-side bundle of uart_rx: serial pin plus received-word outputs.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx_serial_in;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_valid_out;
  logic                 rx_busy_out;
  logic                 rx_frame_err_out;

  modport master (
    input  rx_serial_in,
    output rx_data_out,
    output rx_valid_out,
    output rx_busy_out,
    output rx_frame_err_out
  );

  modport slave (
    output rx_serial_in,
    input  rx_data_out,
    input  rx_valid_out,
    input  rx_busy_out,
    input  rx_frame_err_out
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, DATA_BITS LSB-first, one stop bit).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned OVERSAMPLING = 8,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic      sysclk_in,
  input  logic      nrst_in,
  uart_rx_if.master rx
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW = $clog2(OVERSAMPLING);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic                 sync1;
  logic                 rxs;
  logic                 rxs_prev;
  logic [1:0]           fill;
  logic                 fall;
  logic [PW-1:0]        pre;
  logic                 tick;
  logic [TW-1:0]        tick_cnt;
  logic                 tick_last;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ferr;
  logic [2:0]           state;
  logic                 sample;

  // fill marks when the synchronizer holds real line values, so a line that is
  // already low when reset releases never looks like a falling edge.
  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      fill     <= '0;
      rxs_prev <= 1'b0;
    end else begin
      sync1    <= rx.rx_serial_in;
      rxs      <= sync1;
      fill     <= {fill[0], 1'b1};
      rxs_prev <= fill[1] & rxs;
    end
  end

  assign fall      = rxs_prev & ~rxs;
  assign tick      = (pre == PW'(CLK_DIV - 1));
  assign tick_last = (tick_cnt == TW'(OVERSAMPLING - 1));

`ifdef UART_RX_MAJORITY_EN
  // Decision one tick past centre; the counter restarts there, so later bits
  // inherit the same one-tick offset without further adjustment.
  localparam int unsigned START_AT = OVERSAMPLING / 2;
  logic [1:0] win;

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      win <= '1;
    end else if (tick) begin
      win <= {win[0], rxs};
    end
  end

  assign sample = (win[1] & win[0]) | (win[1] & rxs) | (win[0] & rxs);
`else
  localparam int unsigned START_AT = OVERSAMPLING / 2 - 1;
  assign sample = rxs;
`endif

  generate
    if (DATA_BITS > 1) begin : g_shift
      assign shift_nx = {sample, shift[DATA_BITS-1:1]};
    end else begin : g_shift1
      assign shift_nx = sample;
    end
  endgenerate

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      pre      <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      data     <= '0;
      valid    <= 1'b0;
      ferr     <= 1'b0;
      state    <= S_IDLE;
    end else begin
      valid <= 1'b0;
      ferr  <= 1'b0;
      pre   <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        tick_cnt <= tick_last ? '0 : tick_cnt + TW'(1);
      end

      case (state)
        S_IDLE: begin
          if (fall) begin
            pre      <= '0;
            tick_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (tick && tick_cnt == TW'(START_AT)) begin
            if (!sample) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (tick && tick_last) begin
            shift   <= shift_nx;
            bit_idx <= bit_idx + BW'(1);
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (tick && tick_last) begin
            if (sample) begin
              data  <= shift;
              valid <= 1'b1;
              state <= S_IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (tick && rxs) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx.rx_data_out      = data;
  assign rx.rx_valid_out     = valid;
  assign rx.rx_frame_err_out = ferr;
  assign rx.rx_busy_out      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: cycle-level line-history model plus directed frame scenarios.
module tb_uart_rx;

  localparam int unsigned CD = 4;
  localparam int unsigned OS = 8;
  localparam int unsigned DB = 8;
  localparam int unsigned T  = CD * OS;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MAJ = 1;
`else
  localparam int unsigned MAJ = 0;
`endif
  localparam int HN = 16384;

  logic sysclk = 1'b0;
  logic nrst   = 1'b0;
  logic pin    = 1'b1;

  uart_rx_if #(.DATA_BITS(DB)) rx ();

  uart_rx #(
    .CLK_DIV(CD),
    .OVERSAMPLING(OS),
    .DATA_BITS(DB)
  ) dut (
    .sysclk_in(sysclk),
    .nrst_in(nrst),
    .rx(rx)
  );

  assign rx.rx_serial_in = pin;

  always #5 sysclk = ~sysclk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a frame is judged purely from the history of line levels seen at
  // each rising edge; the receiver sees a level two edges late.
  logic          hist [0:HN-1];
  int            n    = 0;
  int            rel  = 0;
  int            mode = 0;   // 0 idle, 1 in frame, 2 waiting for line high
  int            n0   = 0;
  logic [DB-1:0] e_data  = '0;
  logic          e_valid = 1'b0;
  logic          e_err   = 1'b0;
  logic          e_busy  = 1'b0;

  function automatic logic lvl(input int m);
    return hist[m - 2];
  endfunction

  function automatic logic smp(input int m);
    logic a, b, c;
    if (MAJ != 0) begin
      a = lvl(m - 2 * CD);
      b = lvl(m - CD);
      c = lvl(m);
      return (a & b) | (a & c) | (b & c);
    end
    return lvl(m);
  endfunction

  always @(negedge nrst) begin
    mode    = 0;
    e_data  = '0;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_busy  = 1'b0;
  end

  always @(posedge sysclk) begin
    int ds;
    logic [DB-1:0] w;
    n++;
    if (n < HN) hist[n] = pin;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (!nrst) begin
      mode   = 0;
      e_data = '0;
      rel    = n + 1;
    end else begin
      ds = n0 + int'(CD * (OS / 2 + MAJ));
      case (mode)
        0: if (n - 3 >= rel && hist[n-3] == 1'b1 && hist[n-2] == 1'b0) begin
             n0   = n;
             mode = 1;
           end
        1: if (n == ds && smp(n)) begin
             mode = 0;
           end else if (n == ds + int'(CD * (DB + 1) * OS)) begin
             for (int i = 0; i < int'(DB); i++) w[i] = smp(ds + int'(CD * OS) * (i + 1));
             if (smp(n)) begin
               e_data  = w;
               e_valid = 1'b1;
               mode    = 0;
             end else begin
               e_err = 1'b1;
               mode  = 2;
             end
           end
        2: if ((n - n0) % int'(CD) == 0 && lvl(n)) mode = 0;
        default: mode = 0;
      endcase
    end
    e_busy = (mode != 0);
  end

  int            vcnt = 0;
  int            ecnt = 0;
  time           vtime = 0;
  logic [DB-1:0] words [$];

  always @(negedge sysclk) begin
    chk("busy", 32'(rx.rx_busy_out), 32'(e_busy));
    chk("valid", 32'(rx.rx_valid_out), 32'(e_valid));
    chk("frame_err", 32'(rx.rx_frame_err_out), 32'(e_err));
    chk("data", 32'(rx.rx_data_out), 32'(e_data));
    if (rx.rx_valid_out) begin
      vcnt++;
      vtime = $time;
      words.push_back(rx.rx_data_out);
    end
    if (rx.rx_frame_err_out) ecnt++;
  end

  time t0 = 0;

  task automatic drive(input logic v, input int c);
    pin = v;
    repeat (c) @(negedge sysclk);
  endtask

  task automatic send(input logic [DB-1:0] w, input logic stopv, input int stop_len);
    t0 = $time;
    drive(1'b0, T);
    for (int i = 0; i < int'(DB); i++) drive(w[i], T);
    drive(stopv, stop_len);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, " data"}, 32'(rx.rx_data_out), 32'h0);
    chk({tag, " valid"}, 32'(rx.rx_valid_out), 32'h0);
    chk({tag, " busy"}, 32'(rx.rx_busy_out), 32'h0);
    chk({tag, " frame_err"}, 32'(rx.rx_frame_err_out), 32'h0);
  endtask

  int v0, e0;

  initial begin
    repeat (4) @(negedge sysclk);
    nrst = 1'b1;
    repeat (10) @(negedge sysclk);
    #1 chk_outs_zero("reset");
    @(negedge sysclk);

    // good frame 0xA5
    v0 = vcnt;
    send(8'hA5, 1'b1, T);
    drive(1'b1, T);
    #1;
    chk("a5 pulses", 32'(vcnt - v0), 32'd1);
    chk("a5 word", 32'(rx.rx_data_out), 32'hA5);
    chk("a5 latency", 32'(vtime - t0), (MAJ != 0) ? 32'd3110 : 32'd3070);
    chk("a5 busy after", 32'(rx.rx_busy_out), 32'd0);
    @(negedge sysclk);

    // false start: 8 cycles low
    v0 = vcnt; e0 = ecnt;
    drive(1'b0, 8);
    drive(1'b1, 15);
    #1 chk("false start busy", 32'(rx.rx_busy_out), 32'd0);
    @(negedge sysclk);
    drive(1'b1, T);
    #1;
    chk("false start valid", 32'(vcnt - v0), 32'd0);
    chk("false start err", 32'(ecnt - e0), 32'd0);
    @(negedge sysclk);

    // framing error with line held low
    v0 = vcnt; e0 = ecnt;
    send(8'h3C, 1'b0, 2 * T);
    #1;
    chk("ferr pulses", 32'(ecnt - e0), 32'd1);
    chk("ferr no valid", 32'(vcnt - v0), 32'd0);
    chk("ferr data kept", 32'(rx.rx_data_out), 32'hA5);
    chk("ferr busy in break", 32'(rx.rx_busy_out), 32'd1);
    @(negedge sysclk);
    drive(1'b1, T);
    #1 chk("ferr busy released", 32'(rx.rx_busy_out), 32'd0);
    @(negedge sysclk);

    // back-to-back frames
    v0 = vcnt;
    send(8'h00, 1'b1, T);
    send(8'hFF, 1'b1, T);
    drive(1'b1, T);
    #1;
    chk("b2b pulses", 32'(vcnt - v0), 32'd2);
    chk("b2b first", 32'(words[words.size()-2]), 32'h00);
    chk("b2b second", 32'(words[words.size()-1]), 32'hFF);
    @(negedge sysclk);

    // reset during bit 4 with the line low
    v0 = vcnt; e0 = ecnt;
    drive(1'b0, 4 * T + T / 2);
    #2 nrst = 1'b0;
    #1 chk_outs_zero("mid reset");
    @(negedge sysclk);
    repeat (4) @(negedge sysclk);
    #2 nrst = 1'b1;
    @(negedge sysclk);
    drive(1'b0, 2 * T);
    drive(1'b1, 2 * T);
    #1;
    chk("post reset valid", 32'(vcnt - v0), 32'd0);
    chk("post reset err", 32'(ecnt - e0), 32'd0);
    chk("post reset busy", 32'(rx.rx_busy_out), 32'd0);
    @(negedge sysclk);
    send(8'h5A, 1'b1, T);
    drive(1'b1, T);
    #1;
    chk("5a pulses", 32'(vcnt - v0), 32'd1);
    chk("5a word", 32'(rx.rx_data_out), 32'h5A);
    @(negedge sysclk);

    // glitch on the bit-3 centre of 0x00
    v0 = vcnt;
    drive(1'b0, 4 * T);
    drive(1'b0, 14);
    drive(1'b1, 4);
    drive(1'b0, 14);
    drive(1'b0, 4 * T);
    drive(1'b1, T);
    drive(1'b1, T);
    #1;
    chk("glitch pulses", 32'(vcnt - v0), 32'd1);
    chk("glitch word", 32'(rx.rx_data_out), (MAJ != 0) ? 32'h00 : 32'h08);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Asynchronous serial receiver.
- Recovers 8N1-style frames from the serial line: start bit low, DATA_BITS data bits LSB first, one stop bit high.
- Presents each received word on a parallel bus with a one-cycle valid strobe.
- Sits at the pin side of the UART, mirrors `uart_tx`, and runs entirely in the system clock domain using an internal oversampling prescaler.

## Interface
Parameters:
- CLK_DIV, 4: sysclk cycles per oversample tick (≥1).
- OVERSAMPLING, 8: ticks per bit (even, ≥4).
- DATA_BITS, 8: data bits per frame (1..16).

Ports:
- sysclk_in  in  1  system clock; all logic on rising edge.
- nrst_in  in  1  reset, asynchronous and active-low.
- rx_serial_in  in  1  serial line, asynchronous to sysclk_in, idle high.
- rx_data_out  out  DATA_BITS  last good word; holds until the next good frame.
- rx_valid_out  out  1  one-cycle pulse when rx_data_out is updated.
- rx_busy_out  out  1  high from start-edge detection until return to IDLE.
- rx_frame_err_out  out  1  one-cycle pulse on bad stop bit.

## Operation
- **Input synchronizer:** rx_serial_in passes through a 2-FF synchronizer (reset value 1). All logic uses the synchronized value `rxs`.
- **Prescaler:**
  - Counts 0..CLK_DIV-1 and emits one tick when the count wraps.
  - Cleared on start-edge detection so that bit timing aligns to the edge.
- **State machine:**
  - IDLE:
    - Busy is 0.
    - On rxs 1→0: clear the prescaler and the tick counter, then go to START.
  - START:
    - At tick OVERSAMPLING/2, sample.
    - Sample 0: clear the tick counter and bit index, go to DATA.
    - Sample 1: false start, return to IDLE with no pulse.
  - DATA:
    - Every OVERSAMPLING ticks, sample into shift[bit_idx], then bit_idx+1.
    - After bit DATA_BITS-1, go to STOP.
  - STOP:
    - After OVERSAMPLING ticks, sample.
    - Sample 1: rx_data_out <= shift, pulse rx_valid_out, go to IDLE.
    - Sample 0: pulse rx_frame_err_out, leave rx_data_out unchanged, go to WAIT_HIGH.
  - WAIT_HIGH:
    - Busy stays high; this covers a break condition.
    - Return to IDLE once rxs has been 1 for one tick.
- **Widths:**
  - Tick counter is $clog2(OVERSAMPLING) bits.
  - bit_idx is $clog2(DATA_BITS+1) bits.
  - No wrap past DATA_BITS.
- rx_valid_out and rx_frame_err_out are never high in the same cycle.
- A new start edge is accepted in the first IDLE cycle after STOP, so back-to-back frames are supported.

## Timing
- Bit period: T = CLK_DIV·OVERSAMPLING sysclk cycles.
- Sample points, measured in ticks after start-edge detection:
  - Start: OVERSAMPLING/2.
  - Data bit i: OVERSAMPLING/2 + (i+1)·OVERSAMPLING.
  - Stop: OVERSAMPLING/2 + (DATA_BITS+1)·OVERSAMPLING.
- Input-to-detection latency: 2 sysclk cycles (synchronizer) + 1 cycle (edge detect).
- rx_valid_out / rx_frame_err_out rise 1 sysclk after the stop sample tick and last exactly one cycle.
- Reset values: rx_data_out=0, rx_valid_out=0, rx_busy_out=0, rx_frame_err_out=0, state=IDLE.
- Reset asserted mid-frame:
  - Immediately forces all of the above reset values; no pulse is emitted.
  - After release, a line that is already low is not treated as a start. The receiver waits for a fresh 1→0 edge.
- Tolerance: the design accepts a baud mismatch of ±(OVERSAMPLING/2 − 1) ticks, accumulated over the frame.

## Configuration
- UART_RX_MAJORITY_EN:
  - **Defined:** every sample (start, data, stop) is the 2-of-3 majority of rxs at ticks mid−1, mid and mid+1. The decision is taken at tick mid+1, so the valid/err pulse shifts one tick later.
  - **Undefined:** single sample at tick mid.

## Test plan
With CLK_DIV=4, OVERSAMPLING=8, DATA_BITS=8, T=32 cycles:
1. **Good frame:** send 0xA5 LSB-first with stop=1 → rx_data_out=0xA5 and one rx_valid_out pulse ≈ 9.5·T after the start edge; busy high throughout, low after.
2. **False start:** line low for 8 sysclk then high → no valid/err pulse; busy returns to 0 within T/2+4 cycles.
3. **Framing error:** send 0x3C with stop=0, held low for 2·T → one rx_frame_err_out pulse; rx_data_out keeps its prior value (0xA5); busy stays high until the line returns high.
4. **Back-to-back:** 0x00 then 0xFF with no idle gap → two valid pulses with data 0x00 then 0xFF.
5. **Reset mid-frame:** assert nrst_in during bit 4 while the line is held low → all outputs 0 immediately; after release no pulse until the next full frame 0x5A, which is received correctly.
6. **Glitch at mid-sample:** 4-sysclk high glitch centred on the bit-3 mid-sample of 0x00 → with UART_RX_MAJORITY_EN, rx_data_out=0x00; without it, rx_data_out=0x08.
